// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver with an AXI-Stream style output.
//
// The line is oversampled with a prescaled down-counter. A falling edge in
// idle arms a half-bit wait so the start bit, every data bit and the stop bit
// are sampled near their centres. Characters arrive LSB first. A good stop
// bit writes the character to the output holding register.
//
// Ports
//   clk                clock, all logic on the rising edge
//   rst                asynchronous reset, active low (0 = reset)
//   output_axi_tdata   received character
//   output_axi_tvalid  output_axi_tdata holds an unconsumed character
//   output_axi_tready  consumer takes output_axi_tdata this cycle
//   rxd                serial line, idle high
//   busy               a frame is being received
//   overrun_error      one-cycle pulse: unconsumed character was overwritten
//   frame_error        one-cycle pulse: stop bit sampled low
//   prescale           clocks per 1/8 bit (bit period = prescale * 8 clocks)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] output_axi_tdata,
  output logic                  output_axi_tvalid,
  input  logic                  output_axi_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  // bit_cnt runs DATA_WIDTH+2 (start) .. 1 (stop) .. 0 (idle).
  localparam int CNT_W = $clog2(DATA_WIDTH + 3);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_STOP  = CNT_W'(1);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } phase_e;

  // Registered state
  logic                  rxd_reg;
  logic [18:0]           prescale_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg;
  logic                  busy_reg;
  logic                  overrun_reg;
  logic                  frame_reg;

  // Next-state values
  logic [18:0]           prescale_next;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [DATA_WIDTH-1:0] tdata_next;
  logic                  tvalid_next;
  logic                  busy_next;
  logic                  overrun_next;
  logic                  frame_next;

  phase_e      phase;
  logic [18:0] half_reload;
  logic [18:0] bit_reload;

  // prescale is read only at reload time, so a change mid-frame only affects
  // the next interval. The half-bit load is two short because the falling
  // edge is seen one cycle late and the check costs one more cycle.
  assign half_reload = {1'b0, prescale, 2'b00} - 19'd2;
  assign bit_reload  = {prescale, 3'b000} - 19'd1;

  // Where in the frame we are, decoded from the bit counter.
  always_comb begin
    if (bit_cnt == '0) begin
      phase = PH_IDLE;
    end else if (bit_cnt == CNT_START) begin
      phase = PH_START;
    end else if (bit_cnt == CNT_STOP) begin
      phase = PH_STOP;
    end else begin
      phase = PH_DATA;
    end
  end

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    prescale_next = prescale_reg;
    bit_cnt_next  = bit_cnt;
    data_next     = data_reg;
    tdata_next    = tdata_reg;
    busy_next     = busy_reg;
    overrun_next  = 1'b0;
    frame_next    = 1'b0;
    // A taken character drops tvalid unless a stop bit refills it below.
    tvalid_next   = tvalid_reg && !output_axi_tready;

    if (prescale_reg != '0) begin
      prescale_next = prescale_reg - 19'd1;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          if (!rxd_reg) begin
            prescale_next = half_reload;
            bit_cnt_next  = CNT_START;
            busy_next     = 1'b1;
          end
        end
        PH_START: begin
          if (!rxd_reg) begin
            prescale_next = bit_reload;
            bit_cnt_next  = bit_cnt - 1'b1;
          end else begin
            // Line went high again by mid start bit: treat it as a glitch.
            bit_cnt_next = '0;
            busy_next    = 1'b0;
          end
        end
        PH_DATA: begin
          data_next     = {rxd_reg, data_reg[DATA_WIDTH-1:1]};
          prescale_next = bit_reload;
          bit_cnt_next  = bit_cnt - 1'b1;
        end
        PH_STOP: begin
          // No reload here, so a new start bit is seen on the next cycle.
          bit_cnt_next = '0;
          busy_next    = 1'b0;
          if (rxd_reg) begin
            tdata_next   = data_reg;
            tvalid_next  = 1'b1;
            overrun_next = tvalid_reg && !output_axi_tready;
          end else begin
            frame_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_reg      <= 1'b1;
      prescale_reg <= '0;
      bit_cnt      <= '0;
      data_reg     <= '0;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      frame_reg    <= 1'b0;
    end else begin
      rxd_reg      <= rxd;
      prescale_reg <= prescale_next;
      bit_cnt      <= bit_cnt_next;
      data_reg     <= data_next;
      tdata_reg    <= tdata_next;
      tvalid_reg   <= tvalid_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
      frame_reg    <= frame_next;
    end
  end

  assign output_axi_tdata  = tdata_reg;
  assign output_axi_tvalid = tvalid_reg;
  assign busy              = busy_reg;
  assign overrun_error     = overrun_reg;
  assign frame_error       = frame_reg;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (DATA_WIDTH = 8).
// Inputs change 1 time unit after a rising edge. Outputs are checked either
// at that point or by a falling-edge monitor that counts handshakes and
// error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        rxd;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;
  logic [15:0] prescale;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor results
  int         n_valid_cycles = 0;
  int         n_acc          = 0;
  int         n_ovr          = 0;
  int         n_frm          = 0;
  logic [7:0] last_acc       = 8'h00;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .output_axi_tdata  (tdata),
    .output_axi_tvalid (tvalid),
    .output_axi_tready (tready),
    .rxd               (rxd),
    .busy              (busy),
    .overrun_error     (overrun_error),
    .frame_error       (frame_error),
    .prescale          (prescale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tvalid) n_valid_cycles++;
    if (tvalid && tready) begin
      n_acc++;
      last_acc = tdata;
    end
    if (overrun_error) n_ovr++;
    if (frame_error)   n_frm++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the line at level b for n clocks. Entered and left at posedge + 1.
  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, stop bit, then two idle clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks);
    int bt;
    bt = 8 * int'(prescale);
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    drive_bit(stop, stop_clks);
    drive_bit(1'b1, 2);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, 8 * int'(prescale));
  endtask

  logic [7:0] vec [12] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h55, 8'hAA, 8'hFF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, ovr0, frm0, val0;

    rst      = 1'b0;
    rxd      = 1'b1;
    tready   = 1'b1;
    prescale = 16'd1;

    // Reset state, observed while reset is still asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata",   32'(tdata), 32'h00);
    check("rst_tvalid",  32'(tvalid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_error), 32'd0);
    check("rst_frame",   32'(frame_error), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Walking and pattern bytes at 8 clocks per bit, consumer always ready
    for (int i = 0; i < 12; i++) begin
      send_byte(vec[i]);
      check($sformatf("p1_count_%0d", i), 32'(n_acc), 32'(i + 1));
      check($sformatf("p1_data_%0d", i), 32'(last_acc), 32'(vec[i]));
    end
    check("p1_valid_cycles", 32'(n_valid_cycles), 32'd12);
    check("p1_overrun",      32'(n_ovr), 32'd0);
    check("p1_frame",        32'(n_frm), 32'd0);

    // Overrun: 32 clocks per bit, consumer stalled
    prescale = 16'd4;
    tready   = 1'b0;
    acc0     = n_acc;
    send_byte(8'h5A);
    check("ovr_first_data",  32'(tdata), 32'h5A);
    check("ovr_first_valid", 32'(tvalid), 32'd1);
    check("ovr_first_pulse", 32'(n_ovr), 32'd0);
    send_byte(8'hA5);
    check("ovr_second_data",  32'(tdata), 32'hA5);
    check("ovr_second_valid", 32'(tvalid), 32'd1);
    check("ovr_second_pulse", 32'(n_ovr), 32'd1);
    // One-cycle ready drains the character
    tready = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b0;
    check("ovr_drained_valid", 32'(tvalid), 32'd0);
    check("ovr_drained_count", 32'(n_acc - acc0), 32'd1);
    check("ovr_drained_data",  32'(last_acc), 32'hA5);
    tready = 1'b1;

    // Frame error: 0x33 with a low stop bit held 5/8 of a bit, then idle
    frm0 = n_frm;
    val0 = n_valid_cycles;
    ovr0 = n_ovr;
    send_frame(8'h33, 1'b0, 5 * int'(prescale));
    repeat (12 * int'(prescale)) @(posedge clk);
    #1;
    check("ferr_pulse",   32'(n_frm - frm0), 32'd1);
    check("ferr_novalid", 32'(n_valid_cycles - val0), 32'd0);
    check("ferr_tvalid",  32'(tvalid), 32'd0);
    check("ferr_busy",    32'(busy), 32'd0);
    check("ferr_overrun", 32'(n_ovr - ovr0), 32'd0);

    // Two-clock low glitch at prescale 4
    frm0 = n_frm;
    val0 = n_valid_cycles;
    ovr0 = n_ovr;
    drive_bit(1'b0, 2);
    check("glitch_busy_set", 32'(busy), 32'd1);
    drive_bit(1'b1, 40);
    check("glitch_busy_clr", 32'(busy), 32'd0);
    check("glitch_novalid",  32'(n_valid_cycles - val0), 32'd0);
    check("glitch_noerr",    32'((n_frm - frm0) + (n_ovr - ovr0)), 32'd0);

    // Reset during data bit 3 of 0xC3, then a clean 0x3C
    prescale = 16'd1;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 4);
    check("mid_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_tdata",   32'(tdata), 32'h00);
    check("arst_tvalid",  32'(tvalid), 32'd0);
    check("arst_busy",    32'(busy), 32'd0);
    check("arst_errors",  32'({overrun_error, frame_error}), 32'd0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    acc0 = n_acc;
    frm0 = n_frm;
    send_byte(8'h3C);
    check("post_rst_count", 32'(n_acc - acc0), 32'd1);
    check("post_rst_data",  32'(last_acc), 32'h3C);
    check("post_rst_frame", 32'(n_frm - frm0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per character.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous assert, active-low (0 = reset); one clock, asynchronous active-low reset.
REQ-004 Port: output_axi_tdata  output  DATA_WIDTH  received character.
REQ-005 Port: output_axi_tvalid  output  1  tdata holds an unconsumed character.
REQ-006 Port: output_axi_tready  input  1  consumer accepts tdata this cycle.
REQ-007 Port: rxd  input  1  serial line, idle high.
REQ-008 Port: busy  output  1  frame reception in progress.
REQ-009 Port: overrun_error  output  1  one-cycle pulse, character overwritten before being taken.
REQ-010 Port: frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port: prescale  input  16  clock cycles per 1/8 bit; bit period = prescale*8 clocks.

Function
REQ-012 rxd SHALL pass through one register stage (rxd_reg, reset value 1) before any use; all sampling below refers to rxd_reg.
REQ-013 The block SHALL use a down-counter prescale_reg (19 bits), a bit counter bit_cnt, and a data shift register of DATA_WIDTH bits.
REQ-014 Idle (bit_cnt = 0, prescale_reg = 0): on rxd_reg = 0, load prescale_reg = prescale*4 - 2, bit_cnt = DATA_WIDTH + 2, busy = 1.
REQ-015 While prescale_reg > 0 it SHALL decrement by 1 per clock and take no other action.
REQ-016 Start check (prescale_reg = 0, bit_cnt = DATA_WIDTH + 2): if rxd_reg = 0, load prescale_reg = prescale*8 - 1 and decrement bit_cnt; if rxd_reg = 1 (glitch), set bit_cnt = 0 and busy = 0, with no output and no error.
REQ-017 Data bits (prescale_reg = 0, 1 < bit_cnt <= DATA_WIDTH + 1): shift rxd_reg into the MSB of the shift register (LSB first on the line), load prescale_reg = prescale*8 - 1, decrement bit_cnt.
REQ-018 Stop bit (prescale_reg = 0, bit_cnt = 1): decrement bit_cnt to 0; if rxd_reg = 1, drive output_axi_tdata = shift register, set output_axi_tvalid = 1, and pulse overrun_error = 1 if output_axi_tvalid was already 1; if rxd_reg = 0, pulse frame_error = 1 and leave tdata/tvalid unchanged.
REQ-019 busy SHALL fall in the stop-bit sampling cycle; the next start bit is accepted from the following cycle.
REQ-020 Handshake: output_axi_tvalid SHALL clear in the cycle after output_axi_tready = 1 is sampled with tvalid = 1, unless a new character is written that same cycle; a same-cycle write wins (tvalid stays 1, new data, no overrun pulse when tready was 1).
REQ-021 overrun_error and frame_error SHALL be 1 for exactly one clock per event and 0 otherwise.
REQ-022 Changes to prescale SHALL take effect only at the next counter reload.
REQ-023 prescale = 0 is unsupported; behaviour is don't-care but SHALL NOT lock up beyond a reset.

Reset
REQ-024 While rst = 0, regardless of clk: tdata = 0, tvalid = 0, busy = 0, overrun_error = 0, frame_error = 0, rxd_reg = 1, prescale_reg = 0, bit_cnt = 0.
REQ-025 Reset released mid-frame SHALL return the block to idle; the partial frame is discarded and the next falling edge starts a new frame.

Verification
REQ-026 prescale = 1, tready = 1, send 0x00, 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, 0x55, 0xAA, 0xFF at 8 clocks/bit -> each byte appears on tdata with a one-cycle tvalid pulse, and no errors.
REQ-027 prescale = 4 (32 clocks/bit), tready = 0, send 0x5A then 0xA5 -> tdata = 0x5A after first stop bit; at the second stop bit tdata = 0xA5 and overrun_error pulses once.
REQ-028 Frame with stop bit driven 0 (data 0x33) -> frame_error pulses once, tvalid stays 0, busy returns to 0.
REQ-029 Low glitch of 2 clocks with prescale = 4 -> busy pulses then clears at mid-start check; no tvalid and no error.
REQ-030 rst = 0 asserted during data bit 3 of 0xC3, then released -> outputs are 0 immediately; next full frame 0x3C is received correctly.
